// File: rtl/settings_readback_writer.sv
// Serialises the five persistent settings into the buffer RAM as command/value
// word pairs (optionally zero-terminated) so a dump can be replayed verbatim.
module settings_readback_writer #(
  parameter logic [10:0] BASE_ADDR       = 11'd0,
  parameter bit          EMIT_TERMINATOR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  sel_cmd,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [10:0] word_count,
  input  logic [31:0] set_max_row,
  input  logic [31:0] set_max_col,
  input  logic [31:0] set_data_min,
  input  logic [31:0] set_data_max,
  input  logic [31:0] set_countdown,
  output logic        buf_wr_en,
  output logic [10:0] buf_wr_addr,
  output logic [31:0] buf_wr_data,
  input  logic        buf_wr_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAPSHOT,
    S_WR_CMD,
    S_WR_VAL,
    S_WR_TERM,
    S_FINISH
  } state_t;

  state_t      state_q;
  logic [2:0]  sel_q;
  logic [2:0]  code_q;
  logic        dump_all_q;
  logic [10:0] ptr_q;
  logic [31:0] snap_q [1:5];
  logic [31:0] set_vec [1:5];

  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [10:0] word_count_q;
  logic        wr_en_q;
  logic [10:0] wr_addr_q;
  logic [31:0] wr_data_q;

  logic [10:0] ptr_d;
  logic [2:0]  code_d;
  logic [31:0] snap_val;
  logic        accept;

  // Index the live settings by their command code so capture is a simple loop.
  assign set_vec[1] = set_max_row;
  assign set_vec[2] = set_max_col;
  assign set_vec[3] = set_data_min;
  assign set_vec[4] = set_data_max;
  assign set_vec[5] = set_countdown;

  assign ptr_d  = ptr_q + 11'd1;
  assign code_d = code_q + 3'd1;
  assign accept = wr_en_q & buf_wr_ready;

  always_comb begin
    snap_val = 32'd0;
    case (code_q)
      3'd1:    snap_val = snap_q[1];
      3'd2:    snap_val = snap_q[2];
      3'd3:    snap_val = snap_q[3];
      3'd4:    snap_val = snap_q[4];
      3'd5:    snap_val = snap_q[5];
      default: snap_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= 3'd0;
      code_q       <= 3'd0;
      dump_all_q   <= 1'b0;
      ptr_q        <= 11'd0;
      for (int i = 1; i <= 5; i++) snap_q[i] <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= 11'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 11'd0;
      wr_data_q    <= 32'd0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (sel_cmd >= 3'd6) begin
              error_q <= 1'b1;
            end else begin
              sel_q   <= sel_cmd;
              busy_q  <= 1'b1;
              state_q <= S_SNAPSHOT;
            end
          end
        end

        S_SNAPSHOT: begin
          for (int i = 1; i <= 5; i++) snap_q[i] <= set_vec[i];
          dump_all_q <= (sel_q == 3'd0);
          code_q     <= (sel_q == 3'd0) ? 3'd1 : sel_q;
          ptr_q      <= BASE_ADDR;
          wr_en_q    <= 1'b1;
          wr_addr_q  <= BASE_ADDR;
          wr_data_q  <= {29'd0, (sel_q == 3'd0) ? 3'd1 : sel_q};
          state_q    <= S_WR_CMD;
        end

        S_WR_CMD: begin
          if (accept) begin
            ptr_q     <= ptr_d;
            wr_addr_q <= ptr_d;
            wr_data_q <= snap_val;
            state_q   <= S_WR_VAL;
          end
        end

        S_WR_VAL: begin
          if (accept) begin
            ptr_q <= ptr_d;
            if (dump_all_q && (code_q < 3'd5)) begin
              code_q    <= code_d;
              wr_addr_q <= ptr_d;
              wr_data_q <= {29'd0, code_d};
              state_q   <= S_WR_CMD;
            end else if (EMIT_TERMINATOR) begin
              wr_addr_q <= ptr_d;
              wr_data_q <= 32'd0;
              state_q   <= S_WR_TERM;
            end else begin
              wr_en_q <= 1'b0;
              state_q <= S_FINISH;
            end
          end
        end

        S_WR_TERM: begin
          if (accept) begin
            ptr_q   <= ptr_d;
            wr_en_q <= 1'b0;
            state_q <= S_FINISH;
          end
        end

        S_FINISH: begin
          // Modulo-2048 difference stays correct when the buffer wraps past 2047.
          word_count_q <= ptr_q - BASE_ADDR;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end

        default: begin
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign word_count  = word_count_q;
  assign buf_wr_en   = wr_en_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;

endmodule
